// File: rtl/mem_pkg.sv
// Shared types for the MIPS memory-access stage: access sizes, the MEM/WB bundle
// and the byte-enable helper.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_WORD = 2'b00,
        MEM_HALF = 2'b01,
        MEM_BYTE = 2'b10,
        MEM_RSVD = 2'b11
    } mem_size_t;

    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] read_data;
        logic [4:0]  write_reg;
        logic        reg_write;
        logic        mem_to_reg;
        logic        addr_fault;
    } memwb_t;

    // Little-endian lane mask for an aligned access of the given size.
    function automatic logic [3:0] lane_be(input mem_size_t sz, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (sz)
            MEM_WORD: be = 4'b1111;
            MEM_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            MEM_BYTE: be = 4'b0001 << off;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one interface.
interface mem_stage_if;
    logic        Stall;
    logic        Flush;
    logic [31:0] ALUResultIn;
    logic [31:0] WriteDataIn;
    logic [4:0]  WriteRegIn;
    logic        RegWriteIn;
    logic        MemToRegIn;
    logic        MemWriteIn;
    logic        MemReadIn;
    logic [1:0]  MemSizeIn;
    logic        MemSignedIn;

    logic [31:0] ALUResult;
    logic [31:0] ReadData;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic        MemToReg;
    logic        AddrFault;

    modport master (
        output Stall, Flush, ALUResultIn, WriteDataIn, WriteRegIn, RegWriteIn,
               MemToRegIn, MemWriteIn, MemReadIn, MemSizeIn, MemSignedIn,
        input  ALUResult, ReadData, WriteReg, RegWrite, MemToReg, AddrFault
    );

    modport slave (
        input  Stall, Flush, ALUResultIn, WriteDataIn, WriteRegIn, RegWriteIn,
               MemToRegIn, MemWriteIn, MemReadIn, MemSizeIn, MemSignedIn,
        output ALUResult, ReadData, WriteReg, RegWrite, MemToReg, AddrFault
    );
endinterface

// File: rtl/mem_stage_data_mem.sv
// Data RAM: DEPTH x 32 words, combinational read, synchronous byte-enabled write.
module data_mem #(
    parameter int DEPTH = 256,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: fault decode, store lane steering, load extraction
// and the MEM/WB pipeline register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input logic          clk,
    input logic          rst,
    mem_stage_if.slave   bus
);
    localparam int IDX_W = $clog2(DEPTH);

    mem_size_t        sz;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [31:0]      hi_bits;
    logic             access;
    logic             fault;
    logic             we;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic [31:0]      half_sh;
    logic [31:0]      byte_sh;
    logic [31:0]      load_data;
    memwb_t           wb_d;
    memwb_t           wb_q;

    assign sz      = mem_size_t'(bus.MemSizeIn);
    assign off     = bus.ALUResultIn[1:0];
    assign idx     = bus.ALUResultIn[IDX_W+1:2];
    assign hi_bits = bus.ALUResultIn >> (IDX_W + 2);
    assign access  = bus.MemReadIn | bus.MemWriteIn;

    always_comb begin
        fault = 1'b0;
        if (access) begin
            case (sz)
                MEM_WORD: fault = (off != 2'b00);
                MEM_HALF: fault = off[0];
                MEM_BYTE: fault = 1'b0;
                default:  fault = 1'b1;
            endcase
            if (hi_bits != 32'd0) fault = 1'b1;
        end
    end

    always_comb begin
        wdata = bus.WriteDataIn;
        case (sz)
            MEM_HALF: wdata = {2{bus.WriteDataIn[15:0]}};
            MEM_BYTE: wdata = {4{bus.WriteDataIn[7:0]}};
            default:  wdata = bus.WriteDataIn;
        endcase
    end

    assign be = lane_be(sz, off);
    // rst gating keeps a store presented alongside reset from reaching the RAM.
    assign we = bus.MemWriteIn & ~fault & ~bus.Stall & ~bus.Flush & ~rst;

    data_mem #(.DEPTH(DEPTH)) u_data_mem (
        .clk   (clk),
        .we    (we),
        .be    (be),
        .addr  (idx),
        .wdata (wdata),
        .rdata (rdata)
    );

    assign half_sh = rdata >> {off[1], 4'b0000};
    assign byte_sh = rdata >> {off, 3'b000};

    always_comb begin
        load_data = 32'd0;
        if (bus.MemReadIn && !fault) begin
            case (sz)
                MEM_HALF: load_data = bus.MemSignedIn ? {{16{half_sh[15]}}, half_sh[15:0]}
                                                      : {16'd0, half_sh[15:0]};
                MEM_BYTE: load_data = bus.MemSignedIn ? {{24{byte_sh[7]}}, byte_sh[7:0]}
                                                      : {24'd0, byte_sh[7:0]};
                default:  load_data = rdata;
            endcase
        end
    end

    always_comb begin
        wb_d.alu_result = bus.ALUResultIn;
        wb_d.read_data  = load_data;
        wb_d.write_reg  = bus.WriteRegIn;
        wb_d.reg_write  = bus.RegWriteIn;
        wb_d.mem_to_reg = bus.MemToRegIn;
        wb_d.addr_fault = fault;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            wb_q <= '0;
        else if (bus.Flush) wb_q <= '0;
        else if (!bus.Stall) wb_q <= wb_d;
    end

    assign bus.ALUResult = wb_q.alu_result;
    assign bus.ReadData  = wb_q.read_data;
    assign bus.WriteReg  = wb_q.write_reg;
    assign bus.RegWrite  = wb_q.reg_write;
    assign bus.MemToReg  = wb_q.mem_to_reg;
    assign bus.AddrFault = wb_q.addr_fault;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each step queues its expected MEM/WB bundle and
// compares it after the next rising edge.
module tb_mem_stage;
    import mem_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    memwb_t exp_q[$];
    memwb_t last_exp;

    mem_stage_if bus();

    mem_stage #(.DEPTH(256)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bundle(input string tag, input memwb_t e);
        check({tag, ".ALUResult"}, bus.ALUResult, e.alu_result);
        check({tag, ".ReadData"},  bus.ReadData,  e.read_data);
        check({tag, ".WriteReg"},  {27'd0, bus.WriteReg},  {27'd0, e.write_reg});
        check({tag, ".RegWrite"},  {31'd0, bus.RegWrite},  {31'd0, e.reg_write});
        check({tag, ".MemToReg"},  {31'd0, bus.MemToReg},  {31'd0, e.mem_to_reg});
        check({tag, ".AddrFault"}, {31'd0, bus.AddrFault}, {31'd0, e.addr_fault});
    endtask

    // Drive one EX/MEM bundle, queue what MEM/WB must hold after the edge, then compare.
    task automatic step(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [4:0] wreg, input logic rw, input logic m2r,
                        input logic mw, input logic mr, input logic [1:0] sz, input logic sgn,
                        input logic stall, input logic flush,
                        input logic [31:0] exp_rd, input logic exp_fault);
        memwb_t e;
        memwb_t got;
        bus.ALUResultIn = addr;
        bus.WriteDataIn = wd;
        bus.WriteRegIn  = wreg;
        bus.RegWriteIn  = rw;
        bus.MemToRegIn  = m2r;
        bus.MemWriteIn  = mw;
        bus.MemReadIn   = mr;
        bus.MemSizeIn   = sz;
        bus.MemSignedIn = sgn;
        bus.Stall       = stall;
        bus.Flush       = flush;
        if (flush)      e = '0;
        else if (stall) e = last_exp;
        else            e = '{addr, exp_rd, wreg, rw, m2r, exp_fault};
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_bundle(tag, got);
    endtask

    task automatic idle_inputs();
        bus.Stall = 1'b0; bus.Flush = 1'b0;
        bus.ALUResultIn = '0; bus.WriteDataIn = '0; bus.WriteRegIn = '0;
        bus.RegWriteIn = 1'b0; bus.MemToRegIn = 1'b0; bus.MemWriteIn = 1'b0;
        bus.MemReadIn = 1'b0; bus.MemSizeIn = 2'b00; bus.MemSignedIn = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = '0;
        rst = 1'b1;
        idle_inputs();
        #12;
        check_bundle("reset", '0);
        rst = 1'b0;

        //    tag          addr        wdata        wr rw m2r mw mr sz     s  st fl  exp_rd       flt
        step("sw_10",      32'h10,  32'hDEADBEEF, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0,        0);
        step("lw_10",      32'h10,  32'h0,        5'd8, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'hDEADBEEF, 0);
        step("sb_11",      32'h11,  32'h0000007F, 5'd0, 0, 0, 1, 0, 2'b10, 0, 0, 0, 32'h0,        0);
        step("lw_10b",     32'h10,  32'h0,        5'd9, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'hDEAD7FEF, 0);
        step("lb_13",      32'h13,  32'h0,        5'd3, 1, 1, 0, 1, 2'b10, 1, 0, 0, 32'hFFFFFFDE, 0);
        step("lbu_13",     32'h13,  32'h0,        5'd4, 1, 1, 0, 1, 2'b10, 0, 0, 0, 32'h000000DE, 0);
        step("lh_12",      32'h12,  32'h0,        5'd5, 1, 1, 0, 1, 2'b01, 1, 0, 0, 32'hFFFFDEAD, 0);
        step("lhu_10",     32'h10,  32'h0,        5'd6, 1, 1, 0, 1, 2'b01, 0, 0, 0, 32'h00007FEF, 0);
        step("lb_11",      32'h11,  32'h0,        5'd7, 1, 1, 0, 1, 2'b10, 1, 0, 0, 32'h0000007F, 0);
        step("lw_12_flt",  32'h12,  32'h0,        5'd2, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'h0,        1);
        step("sh_13_flt",  32'h13,  32'h00001234, 5'd0, 0, 0, 1, 0, 2'b01, 0, 0, 0, 32'h0,        1);
        step("lw_10_unch", 32'h10,  32'h0,        5'd1, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'hDEAD7FEF, 0);
        step("lw_400_flt", 32'h400, 32'h0,        5'd1, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'h0,        1);
        step("rsvd_flt",   32'h10,  32'h0,        5'd1, 1, 1, 0, 1, 2'b11, 0, 0, 0, 32'h0,        1);
        step("alu_only",   32'h13,  32'h0,        5'd12,1, 0, 0, 0, 2'b11, 0, 0, 0, 32'h0,        0);
        step("sw_3fc",     32'h3FC, 32'hA5A5A5A5, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0,        0);
        step("lw_3fc",     32'h3FC, 32'h0,        5'd10,1, 1, 0, 1, 2'b00, 0, 0, 0, 32'hA5A5A5A5, 0);

        step("sw_20_init", 32'h20,  32'h11111111, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0,        0);
        step("lw_10_pre",  32'h10,  32'h0,        5'd5, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'hDEAD7FEF, 0);
        step("sw_stall",   32'h20,  32'h22222222, 5'd0, 0, 0, 1, 0, 2'b00, 0, 1, 0, 32'h0,        0);
        step("lw_20_a",    32'h20,  32'h0,        5'd6, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'h11111111, 0);
        step("sw_stfl",    32'h20,  32'h33333333, 5'd0, 0, 0, 1, 0, 2'b00, 0, 1, 1, 32'h0,        0);
        step("lw_20_b",    32'h20,  32'h0,        5'd7, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'h11111111, 0);
        step("sw_commit",  32'h20,  32'h22222222, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0,        0);
        step("lw_20_c",    32'h20,  32'h0,        5'd7, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'h22222222, 0);
        step("sw_b2b",     32'h20,  32'h00000001, 5'd0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 32'h0,        0);
        step("lw_b2b",     32'h20,  32'h0,        5'd8, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'h00000001, 0);

        // Mid-cycle reset while RegWrite=1 with a store pending.
        bus.ALUResultIn = 32'h10; bus.WriteDataIn = 32'h55555555; bus.WriteRegIn = 5'd0;
        bus.RegWriteIn = 1'b0; bus.MemToRegIn = 1'b0; bus.MemWriteIn = 1'b1;
        bus.MemReadIn = 1'b0; bus.MemSizeIn = 2'b00; bus.Stall = 1'b0; bus.Flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_bundle("rst_async", '0);
        @(posedge clk);
        #1;
        check_bundle("rst_hold", '0);
        rst = 1'b0;
        last_exp = '0;
        step("lw_after_rst", 32'h10, 32'h0, 5'd9, 1, 1, 0, 1, 2'b00, 0, 0, 0, 32'hDEAD7FEF, 0);

        n_checks++;
        assert (exp_q.size() == 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage MIPS pipeline, directly upstream of the write-back stage. It takes the EX/MEM bundle, performs word/half/byte loads and stores against an internal data RAM, and registers the MEM/WB bundle that the write-back stage consumes. Stall and flush controls come from the hazard unit.

## Interface
- DEPTH, 256: data RAM size in 32-bit words; power of two, at least 4.
- IDX_W, $clog2(DEPTH): word-index width (localparam, derived).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- Stall  in  1  hold MEM/WB register; suppress store.
- Flush  in  1  insert bubble into MEM/WB; suppress store. Has priority over Stall.
- ALUResultIn  in  32  effective address or ALU result.
- WriteDataIn  in  32  store data (rt).
- WriteRegIn  in  5  destination register.
- RegWriteIn, MemToRegIn, MemWriteIn, MemReadIn  in  1 each  control bits.
- MemSizeIn  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved.
- MemSignedIn  in  1  sign-extend sub-word loads when 1; zero-extend when 0.
- ALUResult, ReadData  out  32  registered, to write-back.
- WriteReg  out  5  registered, to write-back.
- RegWrite, MemToReg  out  1  registered, to write-back.
- AddrFault  out  1  registered; misaligned, out-of-range or reserved-size access.

## Operation
- Word index = ALUResultIn[IDX_W+1:2]; byte offset = ALUResultIn[1:0]; little-endian lanes (offset 0 = bits 7:0).
- Fault when MemReadIn|MemWriteIn and any of: size 11; half with offset[0]=1; word with offset != 0; ALUResultIn[31:IDX_W+2] != 0.
- Store: when MemWriteIn & !Fault & !Stall & !Flush, write the byte lanes selected by size/offset; data is WriteDataIn[7:0] or [15:0] replicated into the target lanes, or the full word. Other lanes unchanged.
- Load: combinational read of the indexed word, then lane extraction (byte/half shifted to bit 0) and sign or zero extension per MemSignedIn. A faulting load yields 0.
- A non-memory op (MemReadIn=MemWriteIn=0) yields ReadData=0 and AddrFault=0.
- The fault does not cancel RegWrite; the hazard/exception logic acts on AddrFault.
- Register update each edge: Flush loads all zeros; else Stall holds; else captures {ALUResultIn, extracted load data, WriteRegIn, RegWriteIn, MemToRegIn, Fault}.

## Timing
- Reset: ALUResult=0, ReadData=0, WriteReg=0, RegWrite=0, MemToReg=0, AddrFault=0. RAM is not reset; its contents are undefined until written.
- Reset mid-operation clears the register immediately (asynchronous) and blocks the RAM write on any edge where rst=1.
- Latency: a load presented in cycle N appears on ReadData in cycle N+1. A store commits at the end of cycle N.
- A load in cycle N+1 to the address stored in cycle N returns the new data; no bypass is needed.
- Simultaneous Stall and Flush: Flush wins. The register is zeroed and the store is suppressed.
- Address aliasing never occurs; the high address bits must be zero or the access faults.

## Structure
- Package mem_pkg: enum mem_size_t {MEM_WORD=2'b00, MEM_HALF=2'b01, MEM_BYTE=2'b10, MEM_RSVD=2'b11}, plus a struct for the MEM/WB bundle.
- Sub-module data_mem: DEPTH×32 array with one combinational read port and one synchronous write port with 4-bit byte enables.
- mem_stage holds the fault decode, lane/byte-enable generation, load extraction and the MEM/WB register.

## Test plan
- Reset: assert rst mid-cycle while RegWrite=1 -> all outputs 0 immediately; a store on that edge is not committed.
- Word store/load: SW 0xDEADBEEF to addr 0x10, then LW 0x10 -> ReadData=0xDEADBEEF one cycle later, MemToReg=1, AddrFault=0.
- Sub-word: after the word above, SB 0x7F to 0x11 -> word = 0xDEAD7FEF. Then:
  - LB 0x13 signed -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 signed -> 0xFFFFDEAD.
- Faults:
  - LW 0x12 -> AddrFault=1, ReadData=0.
  - SH 0x13 -> AddrFault=1, memory unchanged.
  - LW 0x400 with DEPTH=256 -> AddrFault=1.
  - Size 11 -> AddrFault=1.
- Stall/flush:
  - Stall during SW -> no write, outputs held.
  - Stall+Flush together -> outputs zero, no write.
  - Next unstalled cycle -> write commits.
- Back-to-back: SW 0x1 to 0x20 in cycle N, LW 0x20 in cycle N+1 -> ReadData=0x1 in cycle N+2.
